// File: rtl/accum_pkg.sv
// Shared opcode constants and FSM encoding for the parametrised accumulator ALU.
package accum_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_CMP  = 4'd2;
    localparam logic [OP_W-1:0] OP_AND  = 4'd3;
    localparam logic [OP_W-1:0] OP_OR   = 4'd4;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
    localparam logic [OP_W-1:0] OP_LOAD = 4'd6;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd7;

    // Any opcode above this one is rejected with an err pulse.
    localparam logic [OP_W-1:0] OP_LAST_LEGAL = OP_MUL;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/accum_alu_n_if.sv
// Request/result bundle between the datapath controller (master) and the ALU (slave).
interface accum_alu_n_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   op;
    logic             acc_sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] acc;
    logic             cf;
    logic             of;
    logic             zf;
    logic             out_valid;
    logic             err;

    modport master (
        output in_valid, op, acc_sel, a, b, cin,
        input  in_ready, acc, cf, of, zf, out_valid, err
    );

    modport slave (
        input  in_valid, op, acc_sel, a, b, cin,
        output in_ready, acc, cf, of, zf, out_valid, err
    );
endinterface

// File: rtl/accum_alu_core.sv
// Combinational single-cycle ALU: result and flags for ADD..LOAD.
// Build option ACCUM_SATURATE_EN makes ADD/SUB saturate instead of wrapping.
module accum_alu_core
    import accum_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a_val,
    input  logic [WIDTH-1:0] b_val,
    input  logic [WIDTH-1:0] acc_cur,
    input  logic             cin,
    output logic [WIDTH-1:0] res,
    output logic             cf,
    output logic             of,
    output logic             zf
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   dif_s;
    logic [WIDTH-1:0] add_res_s;
    logic [WIDTH-1:0] sub_res_s;

    assign sum_s = {1'b0, a_val} + {1'b0, b_val} + {{WIDTH{1'b0}}, cin};
    assign dif_s = {1'b0, a_val} - {1'b0, b_val} - {{WIDTH{1'b0}}, cin};

`ifdef ACCUM_SATURATE_EN
    assign add_res_s = sum_s[WIDTH] ? {WIDTH{1'b1}} : sum_s[WIDTH-1:0];
    assign sub_res_s = dif_s[WIDTH] ? {WIDTH{1'b0}} : dif_s[WIDTH-1:0];
`else
    assign add_res_s = sum_s[WIDTH-1:0];
    assign sub_res_s = dif_s[WIDTH-1:0];
`endif

    // Opcode decode; overflow always uses the unsaturated sum/difference.
    always_comb begin
        res = acc_cur;
        cf  = 1'b0;
        of  = 1'b0;
        zf  = 1'b0;
        case (op)
            OP_ADD: begin
                res = add_res_s;
                cf  = sum_s[WIDTH];
                of  = (a_val[WIDTH-1] == b_val[WIDTH-1]) && (sum_s[WIDTH-1] != a_val[WIDTH-1]);
            end
            OP_SUB: begin
                res = sub_res_s;
                cf  = dif_s[WIDTH];
                of  = (a_val[WIDTH-1] != b_val[WIDTH-1]) && (dif_s[WIDTH-1] != a_val[WIDTH-1]);
            end
            OP_CMP: begin
                res = acc_cur;
                cf  = (a_val < b_val);
                of  = ($signed(a_val) < $signed(b_val));
            end
            OP_AND:  res = a_val & b_val;
            OP_OR:   res = a_val | b_val;
            OP_NOT:  res = ~a_val;
            OP_LOAD: res = b_val;
            default: res = acc_cur;
        endcase
        if (op == OP_CMP) begin
            zf = (a_val == b_val);
        end else begin
            zf = ~|res;
        end
    end

endmodule

// File: rtl/accum_alu_n.sv
// Accumulator ALU top: handshake, IDLE/MUL FSM, shift-add multiplier and result registers.
// Optional build macro ACCUM_SATURATE_EN (handled in accum_alu_core).
module accum_alu_n
    import accum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input logic          Clk,
    input logic          nReset,
    accum_alu_n_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_r;
    state_t             state_nx_s;
    logic [WIDTH-1:0]   acc_r;
    logic               cf_r;
    logic               of_r;
    logic               zf_r;
    logic               out_valid_r;
    logic               err_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [OPW-1:0]     op_s;
    logic [WIDTH-1:0]   a_sel_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               illegal_s;
    logic [WIDTH-1:0]   core_res_s;
    logic               core_cf_s;
    logic               core_of_s;
    logic               core_zf_s;
    logic [WIDTH:0]     mul_add_s;
    logic [2*WIDTH-1:0] prod_nx_s;

    assign op_s       = bus.op;
    assign a_sel_s    = bus.acc_sel ? acc_r : bus.a;
    assign in_ready_s = (state_r == ST_IDLE);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign illegal_s  = (op_s > OP_LAST_LEGAL);

    accum_alu_core #(.WIDTH(WIDTH)) u_core (
        .op      (op_s),
        .a_val   (a_sel_s),
        .b_val   (bus.b),
        .acc_cur (acc_r),
        .cin     (bus.cin),
        .res     (core_res_s),
        .cf      (core_cf_s),
        .of      (core_of_s),
        .zf      (core_zf_s)
    );

    // Right-shifting multiplier: multiplier sits in the low half, partial sum grows in the high half.
    assign mul_add_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                     + (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    assign prod_nx_s = {mul_add_s, prod_r[WIDTH-1:1]};

    // FSM state register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (op_s == OP_MUL)) begin
                    state_nx_s = ST_MUL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_MUL;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Result/flag registers and multiplier datapath.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            acc_r       <= {WIDTH{1'b0}};
            cf_r        <= 1'b0;
            of_r        <= 1'b0;
            zf_r        <= 1'b0;
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
            prod_r      <= {(2*WIDTH){1'b0}};
            mcand_r     <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
            if (accept_s) begin
                if (illegal_s) begin
                    err_r       <= 1'b1;
                    out_valid_r <= 1'b1;
                end else if (op_s == OP_MUL) begin
                    mcand_r <= a_sel_s;
                    prod_r  <= {{WIDTH{1'b0}}, bus.b};
                    cnt_r   <= CNT_W'(WIDTH);
                end else begin
                    acc_r       <= core_res_s;
                    cf_r        <= core_cf_s;
                    of_r        <= core_of_s;
                    zf_r        <= core_zf_s;
                    out_valid_r <= 1'b1;
                end
            end else if (state_r == ST_MUL) begin
                prod_r <= prod_nx_s;
                cnt_r  <= cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    acc_r       <= prod_nx_s[WIDTH-1:0];
                    cf_r        <= |prod_nx_s[2*WIDTH-1:WIDTH];
                    of_r        <= |prod_nx_s[2*WIDTH-1:WIDTH];
                    zf_r        <= ~|prod_nx_s[WIDTH-1:0];
                    out_valid_r <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.acc       = acc_r;
    assign bus.cf        = cf_r;
    assign bus.of        = of_r;
    assign bus.zf        = zf_r;
    assign bus.out_valid = out_valid_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_accum_alu_n.sv
// Self-checking bench for accum_alu_n at WIDTH=4: arithmetic reference model plus directed pins.
module tb_accum_alu_n;

    localparam int W = 4;
`ifdef ACCUM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] acc;
        logic         cf;
        logic         of;
        logic         zf;
        logic         ill;
        logic         mul;
    } mres_t;

    logic Clk    = 1'b0;
    logic nReset = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;
    bit   done     = 1'b0;

    accum_alu_n_if #(.WIDTH(W), .OPW(4)) bus ();

    accum_alu_n #(.WIDTH(W), .OPW(4)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic mres_t model_op(input int o, input int sel, input int av, input int bv,
                                       input int c, input int accv);
        mres_t r;
        int m, h, x, sa, sb, t;
        m  = (1 << W) - 1;
        h  = 1 << (W - 1);
        x  = (sel != 0) ? accv : av;
        sa = (x >= h) ? x - (1 << W) : x;
        sb = (bv >= h) ? bv - (1 << W) : bv;
        t  = 0;
        r  = '0;
        r.acc = W'(accv);
        case (o)
            0: begin
                t    = x + bv + c;
                r.cf = (t > m);
                r.of = (sa + sb + c > h - 1) || (sa + sb + c < -h);
                r.acc = (SAT && r.cf) ? W'(m) : W'(t);
            end
            1: begin
                t    = x - bv - c;
                r.cf = (t < 0);
                r.of = (sa - sb - c > h - 1) || (sa - sb - c < -h);
                r.acc = (SAT && r.cf) ? W'(0) : W'(t);
            end
            2: begin
                r.cf = (x < bv);
                r.of = (sa < sb);
            end
            3: r.acc = W'(x & bv);
            4: r.acc = W'(x | bv);
            5: r.acc = W'(~x & m);
            6: r.acc = W'(bv);
            7: begin
                t     = x * bv;
                r.acc = W'(t);
                r.cf  = ((t >> W) != 0);
                r.of  = r.cf;
                r.mul = 1'b1;
            end
            default: r.ill = 1'b1;
        endcase
        r.zf = (o == 2) ? (x == bv) : (r.acc == W'(0));
        return r;
    endfunction

    mres_t        m_nxt;
    logic [W-1:0] m_acc = '0;
    logic         m_cf = 1'b0, m_of = 1'b0, m_zf = 1'b0, m_ov = 1'b0, m_err = 1'b0;
    logic [W-1:0] m_pacc = '0;
    logic         m_pcf = 1'b0, m_pof = 1'b0, m_pzf = 1'b0;
    int           m_busy = 0;

    assign m_nxt = model_op(int'(bus.op), int'(bus.acc_sel), int'(bus.a), int'(bus.b),
                            int'(bus.cin), int'(m_acc));

    // Model state: one accept when not busy; multiply completes W edges later.
    always @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            m_acc <= '0; m_cf <= 1'b0; m_of <= 1'b0; m_zf <= 1'b0;
            m_ov <= 1'b0; m_err <= 1'b0; m_busy <= 0;
        end else begin
            m_ov  <= 1'b0;
            m_err <= 1'b0;
            if (m_busy != 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_acc <= m_pacc; m_cf <= m_pcf; m_of <= m_pof; m_zf <= m_pzf;
                    m_ov  <= 1'b1;
                end
            end else if (bus.in_valid === 1'b1) begin
                if (m_nxt.ill) begin
                    m_err <= 1'b1;
                    m_ov  <= 1'b1;
                end else if (m_nxt.mul) begin
                    m_busy <= W;
                    m_pacc <= m_nxt.acc; m_pcf <= m_nxt.cf; m_pof <= m_nxt.of; m_pzf <= m_nxt.zf;
                end else begin
                    m_acc <= m_nxt.acc; m_cf <= m_nxt.cf; m_of <= m_nxt.of; m_zf <= m_nxt.zf;
                    m_ov  <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        @(posedge Clk);
        forever begin
            @(negedge Clk);
            if (!done) begin
                check("in_ready",  32'(bus.in_ready),  32'(m_busy == 0));
                check("out_valid", 32'(bus.out_valid), 32'(m_ov));
                check("err",       32'(bus.err),       32'(m_err));
                check("acc",       32'(bus.acc),       32'(m_acc));
                check("cf",        32'(bus.cf),        32'(m_cf));
                check("of",        32'(bus.of),        32'(m_of));
                check("zf",        32'(bus.zf),        32'(m_zf));
            end
        end
    end

    task automatic issue(input int o, input int sel, input int av, input int bv, input int c);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.op       = 4'(o);
        bus.acc_sel  = 1'(sel);
        bus.a        = W'(av);
        bus.b        = W'(bv);
        bus.cin      = 1'(c);
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 40) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required high within 40", n);
        end
        @(negedge Clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ov(input string name);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check(name, 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        bus.in_valid = 1'b0; bus.op = 4'd0; bus.acc_sel = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (2) @(posedge Clk);
        #2 nReset = 1'b1;
        @(negedge Clk);
        check("rst_acc", 32'(bus.acc), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_flags", 32'({bus.cf, bus.of, bus.zf, bus.err}), 32'd0);

        issue(6, 0, 0, 15, 0);
        issue(0, 1, 0, 1, 0);
        check("add_carry_acc", 32'(bus.acc), SAT ? 32'd15 : 32'd0);
        check("add_carry_cf", 32'(bus.cf), 32'd1);
        check("add_carry_of", 32'(bus.of), 32'd0);
        check("add_carry_zf", 32'(bus.zf), SAT ? 32'd0 : 32'd1);
        check("add_carry_ov", 32'(bus.out_valid), 32'd1);
        @(negedge Clk);
        check("add_ov_pulse_end", 32'(bus.out_valid), 32'd0);

        issue(1, 0, 7, 12, 0);
        check("sub_borrow_acc", 32'(bus.acc), SAT ? 32'd0 : 32'd11);
        check("sub_borrow_cf_of", 32'({bus.cf, bus.of}), 32'd3);
        issue(1, 0, 10, 5, 0);
        check("sub_ovf_acc", 32'(bus.acc), 32'd5);
        check("sub_ovf_cf_of", 32'({bus.cf, bus.of}), 32'd1);

        issue(6, 0, 0, 3, 0);
        issue(2, 0, 7, 12, 0);
        check("cmp_acc", 32'(bus.acc), 32'd3);
        check("cmp_flags", 32'({bus.cf, bus.of, bus.zf}), 32'b100);
        issue(2, 0, 5, 5, 0);
        check("cmp_eq_zf", 32'(bus.zf), 32'd1);

        issue(3, 0, 7, 12, 0);
        check("and_acc", 32'(bus.acc), 32'd4);
        issue(4, 0, 7, 12, 0);
        check("or_acc", 32'(bus.acc), 32'd15);
        issue(5, 0, 9, 0, 0);
        check("not_acc", 32'(bus.acc), 32'd6);

        issue(12, 0, 1, 1, 1);
        check("ill_err", 32'(bus.err), 32'd1);
        check("ill_ov", 32'(bus.out_valid), 32'd1);
        check("ill_acc", 32'(bus.acc), 32'd6);
        @(negedge Clk);
        check("ill_err_end", 32'(bus.err), 32'd0);

        issue(7, 0, 7, 12, 0);
        lows = 0;
        while (bus.in_ready === 1'b0 && lows < 40) begin
            lows++;
            @(negedge Clk);
        end
        check("mul_busy_cycles", 32'(lows), 32'(W));
        check("mul_ov", 32'(bus.out_valid), 32'd1);
        check("mul_acc", 32'(bus.acc), 32'd4);
        check("mul_cf_of", 32'({bus.cf, bus.of}), 32'd3);

        issue(7, 0, 3, 3, 0);
        issue(0, 1, 0, 1, 0);
        check("held_after_mul_acc", 32'(bus.acc), 32'd10);

        issue(6, 0, 0, 3, 0);
        issue(7, 1, 9, 5, 0);
        wait_ov("mul_chain_ov");
        check("mul_chain_acc", 32'(bus.acc), 32'd15);
        check("mul_chain_cf", 32'(bus.cf), 32'd0);

        issue(0, 0, 7, 0, 1);
        check("add_cin_acc", 32'(bus.acc), 32'd8);
        check("add_cin_of", 32'(bus.of), 32'd1);
        issue(1, 0, 8, 0, 1);
        check("sub_bin_acc", 32'(bus.acc), 32'd7);
        check("sub_bin_of", 32'(bus.of), 32'd1);

        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(0, 8)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 1)));
        end
        repeat (W + 2) @(negedge Clk);

        issue(7, 0, 15, 15, 0);
        @(posedge Clk);
        @(posedge Clk);
        #2 nReset = 1'b0;
        #1;
        check("rst_mul_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mul_acc", 32'(bus.acc), 32'd0);
        check("rst_mul_flags", 32'({bus.cf, bus.of, bus.zf, bus.out_valid}), 32'd0);
        @(posedge Clk);
        #2 nReset = 1'b1;
        repeat (W + 2) begin
            @(negedge Clk);
            check("rst_mul_no_ov", 32'(bus.out_valid), 32'd0);
        end

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
